// File: rtl/fads_pkg.sv
// Shared types and constants for the multi-channel droplet sorter:
// FSM states, register map offsets and log-entry layout.
package fads_pkg;

  typedef enum logic [1:0] {IDLE, ACQ, EVAL} fads_state_e;

  // Per-channel threshold offsets, added to 0x10*channel
  localparam logic [19:0] REG_CH_MIN   = 20'h000;
  localparam logic [19:0] REG_CH_LOW   = 20'h004;
  localparam logic [19:0] REG_CH_HIGH  = 20'h008;
  localparam logic [19:0] REG_W_MIN    = 20'h100;
  localparam logic [19:0] REG_W_LOW    = 20'h104;
  localparam logic [19:0] REG_W_HIGH   = 20'h108;
  localparam logic [19:0] REG_CTRL     = 20'h110;
  localparam logic [19:0] REG_SORT_DLY = 20'h114;
  localparam logic [19:0] REG_SORT_DUR = 20'h118;
  localparam logic [19:0] REG_DROP_ID  = 20'h200;
  localparam logic [19:0] REG_POS      = 20'h204;
  localparam logic [19:0] REG_NEG      = 20'h208;
  localparam logic [19:0] REG_DROPPED  = 20'h20C;
  localparam logic [19:0] REG_LOG_OVF  = 20'h210;
  localparam logic [19:0] REG_LOG_POP  = 20'h300;
  localparam logic [19:0] REG_LOG_LVL  = 20'h304;

  localparam int unsigned CTRL_CLEAR    = 0;
  localparam int unsigned CTRL_SORT_EN  = 1;
  localparam int unsigned CTRL_ACQ_EN   = 2;
  localparam int unsigned CTRL_MASK_LSB = 8;

  // Log entry = {class[7:0], width[23:0]}
  localparam int unsigned LOG_WIDTH_W   = 24;
  localparam int unsigned LOG_CLASS_LSB = 24;
  localparam int unsigned CLS_POS       = 7;
  localparam int unsigned CLS_WLOW      = 6;
  localparam int unsigned CLS_WHIGH     = 5;

endpackage

// File: rtl/red_pitaya_fads_mc_if.sv
// System-bus slave port of the droplet sorter.
interface red_pitaya_fads_mc_if;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic [3:0]  sys_sel;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  modport master (output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
                  input  sys_rdata, sys_err, sys_ack);
  modport slave  (input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
                  output sys_rdata, sys_err, sys_ack);
endinterface

// File: rtl/fads_sync_fifo.sv
// Single-clock FIFO with a combinational head; on a full FIFO a same-cycle
// pop frees the slot that the push then takes.
module fads_sync_fifo #(
  parameter int unsigned W = 32,
  parameter int unsigned D = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 push,
  input  logic                 pop,
  input  logic [W-1:0]         wdata,
  output logic [W-1:0]         rdata,
  output logic                 full,
  output logic                 empty,
  output logic [$clog2(D):0]   level
);
  localparam int unsigned AW = $clog2(D);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem [D];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && !clr && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/red_pitaya_fads_mc.sv
// Multi-channel droplet sorter: gates on channel 0, tracks per-channel peaks,
// classifies against windows, schedules delayed sort pulses and logs events.
module red_pitaya_fads_mc
  import fads_pkg::*;
#(
  parameter int unsigned NCH     = 2,
  parameter int unsigned DW      = 14,
  parameter int unsigned CW      = 32,
  parameter int unsigned QD      = 8,
  parameter int unsigned LOGD    = 16,
  parameter logic [31:0] TS_INIT = 32'd0
) (
  input  logic                adc_clk_i,
  input  logic                adc_rst_i,
  input  logic [NCH*DW-1:0]   adc_i,
  output logic                sort_trig_o,
  red_pitaya_fads_mc_if.slave sys
);
  localparam int unsigned QLW = $clog2(QD) + 1;
  localparam int unsigned LLW = $clog2(LOGD) + 1;

  logic signed [DW-1:0] smp [NCH];
  logic signed [DW-1:0] thr_min [NCH], thr_low [NCH], thr_high [NCH], peak [NCH];
  logic [CW-1:0] wmin, wlow, whigh, sort_delay, sort_dur;
  logic          sort_en, acq_en;
  logic [7:0]    ch_mask;
  fads_state_e   state, state_nxt;
  logic [CW-1:0] width, ts, remaining, rem_nxt;
  logic [CW-1:0] cnt_id, cnt_pos, cnt_neg, cnt_drop, cnt_ovf;
  logic [19:0]   addr;
  logic          wr, rd, clr, log_rd;
  logic [31:0]   rdata_nxt, rdata_q;
  logic          ack_q;
  logic [NCH-1:0] ch_in;
  logic [7:0]    cls;
  logic          w_lo, w_hi, valid, pos, evt, fire;
  logic          q_full, q_empty, q_push, q_drop, log_full, log_empty, log_ovf;
  logic [CW-1:0] q_head, head_diff;
  logic [31:0]   log_head, log_entry;
  logic [QLW-1:0] q_level;
  logic [LLW-1:0] log_level;
  logic          unused_ok;

  assign addr   = sys.sys_addr[19:0];
  assign wr     = sys.sys_wen;
  assign rd     = sys.sys_ren;
  assign clr    = wr && (addr == REG_CTRL) && sys.sys_wdata[CTRL_CLEAR];
  assign log_rd = rd && (addr == REG_LOG_POP);
  assign sys.sys_err   = 1'b0;
  assign sys.sys_ack   = ack_q;
  assign sys.sys_rdata = rdata_q;
  assign unused_ok = ^{sys.sys_sel, sys.sys_addr[31:20], ch_mask, q_level};

  always_comb begin
    for (int k = 0; k < int'(NCH); k++) smp[k] = adc_i[k*DW +: DW];
  end

  // Configuration registers: threshold and control writes
  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      for (int k = 0; k < int'(NCH); k++) begin
        thr_min[k]  <= DW'(15);
        thr_low[k]  <= DW'(16);
        thr_high[k] <= DW'(255);
      end
      wmin       <= CW'(1);
      wlow       <= ~CW'(1);
      whigh      <= '1;
      sort_delay <= CW'(31250);
      sort_dur   <= CW'(125000);
      sort_en    <= 1'b1;
      acq_en     <= 1'b1;
      ch_mask    <= '1;
    end else if (wr) begin
      for (int k = 0; k < int'(NCH); k++) begin
        if (addr == 20'(16*k) + REG_CH_MIN)  thr_min[k]  <= sys.sys_wdata[DW-1:0];
        if (addr == 20'(16*k) + REG_CH_LOW)  thr_low[k]  <= sys.sys_wdata[DW-1:0];
        if (addr == 20'(16*k) + REG_CH_HIGH) thr_high[k] <= sys.sys_wdata[DW-1:0];
      end
      case (addr)
        REG_W_MIN:    wmin       <= CW'(sys.sys_wdata);
        REG_W_LOW:    wlow       <= CW'(sys.sys_wdata);
        REG_W_HIGH:   whigh      <= CW'(sys.sys_wdata);
        REG_SORT_DLY: sort_delay <= CW'(sys.sys_wdata);
        REG_SORT_DUR: sort_dur   <= CW'(sys.sys_wdata);
        REG_CTRL: begin
          sort_en <= sys.sys_wdata[CTRL_SORT_EN];
          acq_en  <= sys.sys_wdata[CTRL_ACQ_EN];
          ch_mask <= sys.sys_wdata[CTRL_MASK_LSB +: 8];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_nxt = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (addr == 20'(16*k) + REG_CH_MIN)  rdata_nxt = 32'(thr_min[k]);
      if (addr == 20'(16*k) + REG_CH_LOW)  rdata_nxt = 32'(thr_low[k]);
      if (addr == 20'(16*k) + REG_CH_HIGH) rdata_nxt = 32'(thr_high[k]);
    end
    case (addr)
      REG_W_MIN:    rdata_nxt = 32'(wmin);
      REG_W_LOW:    rdata_nxt = 32'(wlow);
      REG_W_HIGH:   rdata_nxt = 32'(whigh);
      REG_CTRL:     rdata_nxt = {16'd0, ch_mask, 5'd0, acq_en, sort_en, 1'b0};
      REG_SORT_DLY: rdata_nxt = 32'(sort_delay);
      REG_SORT_DUR: rdata_nxt = 32'(sort_dur);
      REG_DROP_ID:  rdata_nxt = 32'(cnt_id);
      REG_POS:      rdata_nxt = 32'(cnt_pos);
      REG_NEG:      rdata_nxt = 32'(cnt_neg);
      REG_DROPPED:  rdata_nxt = 32'(cnt_drop);
      REG_LOG_OVF:  rdata_nxt = 32'(cnt_ovf);
      REG_LOG_POP:  rdata_nxt = log_empty ? 32'd0 : log_head;
      REG_LOG_LVL:  rdata_nxt = 32'(log_level);
      default: ;
    endcase
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= wr | rd;
      rdata_q <= rd ? rdata_nxt : 32'd0;
    end
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acq_en && (smp[0] >= thr_min[0])) state_nxt = ACQ;
      ACQ:     if (smp[0] < thr_min[0]) state_nxt = EVAL;
      EVAL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // Width counter and per-channel running peaks
  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      width <= '0;
      for (int k = 0; k < int'(NCH); k++) peak[k] <= '0;
    end else if (state == IDLE && state_nxt == ACQ) begin
      width <= CW'(1);
      for (int k = 0; k < int'(NCH); k++) peak[k] <= smp[k];
    end else if (state == ACQ && state_nxt == ACQ) begin
      if (~&width) width <= width + CW'(1);
      for (int k = 0; k < int'(NCH); k++) if (smp[k] > peak[k]) peak[k] <= smp[k];
    end
  end

  always_comb begin
    for (int k = 0; k < int'(NCH); k++)
      ch_in[k] = (peak[k] >= thr_low[k]) && (peak[k] < thr_high[k]);
  end

  assign w_lo  = width < wlow;
  assign w_hi  = width >= whigh;
  assign valid = width >= wmin;
  assign pos   = !w_lo && !w_hi && (&(ch_in | ~ch_mask[NCH-1:0]));
  assign evt   = (state == EVAL) && valid && !clr;

  always_comb begin
    cls             = '0;
    cls[NCH-1:0]    = ch_in;
    cls[CLS_WHIGH]  = w_hi;
    cls[CLS_WLOW]   = w_lo;
    cls[CLS_POS]    = pos;
    log_entry[LOG_CLASS_LSB +: 8] = cls;
    log_entry[LOG_WIDTH_W-1:0]    = (width > CW'(24'hFF_FFFF)) ? 24'hFF_FFFF : width[LOG_WIDTH_W-1:0];
  end

  assign q_push    = evt && pos && sort_en && !q_full;
  assign q_drop    = evt && pos && sort_en && q_full;
  assign log_ovf   = evt && log_full && !log_rd;
  assign head_diff = ts - q_head;
  assign fire      = !q_empty && !head_diff[CW-1] && !clr;

  fads_sync_fifo #(.W(CW), .D(QD)) u_sort_q (
    .clk(adc_clk_i), .rst(adc_rst_i), .clr(clr), .push(q_push), .pop(fire),
    .wdata(ts + sort_delay), .rdata(q_head), .full(q_full), .empty(q_empty),
    .level(q_level));

  fads_sync_fifo #(.W(32), .D(LOGD)) u_log (
    .clk(adc_clk_i), .rst(adc_rst_i), .clr(clr), .push(evt), .pop(log_rd),
    .wdata(log_entry), .rdata(log_head), .full(log_full), .empty(log_empty),
    .level(log_level));

  // Pulse timer: a new fire reloads, which extends an active pulse
  always_comb begin
    rem_nxt = remaining;
    if (fire)                 rem_nxt = sort_dur;
    else if (remaining != '0) rem_nxt = remaining - CW'(1);
    if (clr)                  rem_nxt = '0;
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      ts          <= CW'(TS_INIT);
      remaining   <= '0;
      sort_trig_o <= 1'b0;
    end else begin
      ts          <= ts + CW'(1);
      remaining   <= rem_nxt;
      sort_trig_o <= (rem_nxt != '0);
    end
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      cnt_id <= '0; cnt_pos <= '0; cnt_neg <= '0; cnt_drop <= '0; cnt_ovf <= '0;
    end else if (clr) begin
      cnt_id <= '0; cnt_pos <= '0; cnt_neg <= '0; cnt_drop <= '0; cnt_ovf <= '0;
    end else begin
      if (evt) begin
        cnt_id <= cnt_id + CW'(1);
        if (pos) cnt_pos <= cnt_pos + CW'(1);
        else     cnt_neg <= cnt_neg + CW'(1);
      end
      if (q_drop)  cnt_drop <= cnt_drop + CW'(1);
      if (log_ovf) cnt_ovf  <= cnt_ovf + CW'(1);
    end
  end
endmodule
